ofm_drain_unit: RTL

// Downstream stage of the 256-PE convolution array. Captures the full OFM vector when every PE

---
 rtl/ofm_drain_if.sv | 30 +++
 rtl/ofm_drain_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/ofm_drain_if.sv
// OFM drain bundle: PE-array capture side, output beat stream and status flags.
interface ofm_drain_if #(
  parameter int NUM_PE    = 256,
  parameter int DATA_W    = 8,
  parameter int OUT_LANES = 32
);
  localparam int BEATS = NUM_PE / OUT_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [NUM_PE-1:0]                 pe_valid;
  logic [NUM_PE-1:0][DATA_W-1:0]     pe_ofm;
  logic                              out_valid;
  logic                              out_ready;
  logic [OUT_LANES-1:0][DATA_W-1:0]  out_data;
  logic [BW-1:0]                     out_beat_idx;
  logic                              out_last;
  logic                              busy;
  logic                              overflow;
  logic                              lane_err;
  logic                              clr_err;

  modport master (
    input  pe_valid, pe_ofm, out_ready, clr_err,
    output out_valid, out_data, out_beat_idx, out_last, busy, overflow, lane_err
  );
  modport slave (
    output pe_valid, pe_ofm, out_ready, clr_err,
    input  out_valid, out_data, out_beat_idx, out_last, busy, overflow, lane_err
  );
endinterface

// File: rtl/ofm_drain_unit.sv
// Two-bank ping-pong capture of the PE-array OFM vector, drained as OUT_LANES-wide beats.
module ofm_drain_unit #(
  parameter int NUM_PE    = 256,
  parameter int DATA_W    = 8,
  parameter int OUT_LANES = 32
) (
  input logic        clk,
  input logic        reset,
  ofm_drain_if.master bus
);
  localparam int BEATS = NUM_PE / OUT_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef logic [NUM_PE-1:0][DATA_W-1:0]    vec_t;
  typedef logic [OUT_LANES-1:0][DATA_W-1:0] beat_t;
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t        state_q, state_d;
  vec_t          bank_q [2];
  vec_t          src;
  logic [1:0]    full_q, full_d, full_eff;
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  beat_t         data_q, data_d;
  logic          ovf_q, ovf_d, lerr_q, lerr_d;
  logic          all_one, mixed, xfer, rel, cap, drop;

  always_comb begin
    all_one  = &bus.pe_valid;
    mixed    = (|bus.pe_valid) && !all_one;
    xfer     = (state_q == DRAIN) && bus.out_ready;
    rel      = xfer && (beat_q == LAST_BEAT);
    // A bank whose last beat leaves this cycle is already free for a capture.
    full_eff = full_q;
    if (rel) full_eff[rd_ptr_q] = 1'b0;
    cap      = all_one && !full_eff[wr_ptr_q];
    drop     = all_one &&  full_eff[wr_ptr_q];

    full_d   = full_eff;
    wr_ptr_d = wr_ptr_q;
    if (cap) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end

    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    if (xfer) begin
      if (rel) begin
        rd_ptr_d = ~rd_ptr_q;
        beat_d   = '0;
      end else begin
        beat_d   = beat_q + 1'b1;
      end
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (full_d[rd_ptr_d]) state_d = DRAIN;
      DRAIN:   if (rel && !full_d[rd_ptr_d]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output beat is registered from next-state so beat 0 appears right after capture.
    src    = (cap && (wr_ptr_q == rd_ptr_d)) ? bus.pe_ofm : bank_q[rd_ptr_d];
    data_d = '0;
    if (state_d == DRAIN) data_d = src[int'(beat_d) * OUT_LANES +: OUT_LANES];

    ovf_d  = bus.clr_err ? 1'b0 : (ovf_q  | drop);
    lerr_d = bus.clr_err ? 1'b0 : (lerr_q | mixed);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      lerr_q   <= lerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) bank_q[wr_ptr_q] <= bus.pe_ofm;
  end

  assign bus.out_valid    = (state_q == DRAIN);
  assign bus.out_data     = data_q;
  assign bus.out_beat_idx = beat_q;
  assign bus.out_last     = (state_q == DRAIN) && (beat_q == LAST_BEAT);
  assign bus.busy         = |full_q;
  assign bus.overflow     = ovf_q;
  assign bus.lane_err     = lerr_q;
endmodule
